// File: rtl/apb_master_ctrl.sv
// APB-side sequencer of the AHB-to-APB bridge: takes one request at a time,
// decodes it to a slave select and runs the SETUP/ACCESS phases, returning one response.
module apb_master_ctrl #(
    parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
    parameter logic [31:0] WIN_SIZE  = 32'h0400_0000
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        pwrite,
    output logic        penable,
    output logic [2:0]  psel,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [2:0]  dec_sel;
    logic        accept;

    // Offset compare keeps addresses far above a window from wrapping into it.
    always_comb begin
        dec_sel    = 3'b000;
        dec_sel[0] = (req_addr - SLV0_BASE) < WIN_SIZE;
        dec_sel[1] = (req_addr - SLV1_BASE) < WIN_SIZE;
        dec_sel[2] = (req_addr - SLV2_BASE) < WIN_SIZE;
    end

    assign req_ready = (state_q == IDLE) || (state_q == ACCESS);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;

        unique case (state_q)
            IDLE: begin
                psel_d    = 3'b000;
                penable_d = 1'b0;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                state_d     = IDLE;
                psel_d      = 3'b000;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = pwrite_q ? 32'h0 : prdata;
            end
            ERR: begin
                state_d     = IDLE;
                psel_d      = 3'b000;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 3'b000;
                penable_d = 1'b0;
            end
        endcase

        // A new request may be taken in IDLE or in the last ACCESS cycle.
        if (accept) begin
            penable_d = 1'b0;
            if (|dec_sel) begin
                state_d  = SETUP;
                psel_d   = dec_sel;
                pwrite_d = req_write;
                paddr_d  = req_addr;
                pwdata_d = req_wdata;
            end else begin
                state_d = ERR;
                psel_d  = 3'b000;
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= IDLE;
            psel_q      <= 3'b000;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
